router_fsm: RTL

Control state machine for the 1x3 router input side. It sequences header decode, payload load, FIFO-full stall and parity check for each incoming packet. It drives the strobes that tell the input register block when to capture header, payload and parity. It also drives the synchroniser's address latch (detect_add) and write gating (write_enb_reg), and aborts a packet on a per-FIFO soft reset.

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router input-side control logic.
//   state_t   : 3-bit binary encoding of the eight controller states
//   ADDR_P*   : destination port addresses
//   NUM_PORTS : number of output FIFOs. Addresses 0..NUM_PORTS-1 are routable.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam int ADDR_P0 = 0;
    localparam int ADDR_P1 = 1;
    localparam int ADDR_P2 = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    // True when an address selects one of the existing output FIFOs.
    function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < NUM_PORTS);
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router input-side controller.
// Sequences each packet through header decode, payload load, full-FIFO stall
// and parity check. All outputs are Moore outputs decoded from the state
// register, so nothing here has a combinational path from an input.
//
// Ports:
//   clk, resetn         : clock, asynchronous active-low reset
//   pkt_valid           : byte stream valid; falls on the parity byte
//   data_in             : destination address bits of the header byte
//   parity_done         : input register has captured the parity byte
//   low_pkt_valid       : pkt_valid fell while stalled on a full FIFO
//   fifo_full           : full flag of the currently addressed FIFO
//   fifo_empty_0/1/2    : empty flags of each output FIFO
//   soft_reset_0/1/2    : per-FIFO timeout reset from the synchroniser
//   detect_add          : header decode cycle (address latch strobe)
//   lfd_state           : header write cycle
//   ld_state            : payload write cycle
//   laf_state           : first cycle after a full stall
//   full_state          : stalled on a full FIFO
//   write_enb_reg       : FIFO write request
//   rst_int_reg         : clears the internal parity registers
//   busy                : input port is not accepting new bytes
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W    = router_pkg::ADDR_W,
    parameter int NUM_PORTS = router_pkg::NUM_PORTS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;

    logic [2:0]        empty_vec;
    logic [2:0]        soft_vec;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_empty;
    logic              sel_valid;
    logic              soft_hit;

    assign empty_vec[ADDR_P0] = fifo_empty_0;
    assign empty_vec[ADDR_P1] = fifo_empty_1;
    assign empty_vec[ADDR_P2] = fifo_empty_2;

    assign soft_vec[ADDR_P0]  = soft_reset_0;
    assign soft_vec[ADDR_P1]  = soft_reset_1;
    assign soft_vec[ADDR_P2]  = soft_reset_2;

    // While decoding, the address register has not yet captured the header,
    // so the empty check has to look at the incoming address bits directly.
    assign sel_addr  = (state_reg == DECODE_ADDRESS) ? data_in : addr_reg;
    assign sel_valid = (int'(sel_addr) < NUM_PORTS);

    always_comb begin
        sel_empty = 1'b0;
        soft_hit  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_addr == ADDR_W'(i)) begin
                sel_empty = empty_vec[i];
            end
            // Only a timeout on the FIFO this packet targets aborts it.
            if (soft_vec[i] && (addr_reg == ADDR_W'(i))) begin
                soft_hit = 1'b1;
            end
        end
    end

    // Address register: captured on every valid-qualified decode cycle.
    always_comb begin
        addr_next = addr_reg;
        if ((state_reg == DECODE_ADDRESS) && pkt_valid) begin
            addr_next = data_in;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            DECODE_ADDRESS: begin
                if (pkt_valid && sel_valid) begin
                    state_next = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) begin
                    state_next = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                // A full FIFO wins over the end of packet; the parity byte
                // is then recovered through low_pkt_valid after the stall.
                if (fifo_full) begin
                    state_next = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_next = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_next = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_next = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_next = LOAD_PARITY;
                end else begin
                    state_next = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_next = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_next = DECODE_ADDRESS;
            end
        endcase

        if (soft_hit) begin
            state_next = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Moore output decode.
    assign detect_add    = (state_reg == DECODE_ADDRESS);
    assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign ld_state      = (state_reg == LOAD_DATA);
    assign laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign full_state    = (state_reg == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_reg == LOAD_DATA)
                        || (state_reg == LOAD_PARITY)
                        || (state_reg == LOAD_AFTER_FULL);
    assign busy          = (state_reg != DECODE_ADDRESS)
                        && (state_reg != LOAD_DATA);

endmodule
